// File: rtl/reg_rd_burst.sv
// Burst read sequencer: turns one {base, length} command into single reads on the
// register read channel and streams the returned words out through a small FWFT FIFO.
module reg_rd_burst #(
    parameter int K_DWIDTH     = 8,
    parameter int K_AWIDTH     = 16,
    parameter int K_LWIDTH     = 8,
    parameter int K_FIFO_DEPTH = 4,
    parameter int K_TIMEOUT    = 15
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [K_AWIDTH-1:0] i_base_addr,
    input  logic [K_LWIDTH-1:0] i_len,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [K_AWIDTH-1:0] o_rd_addr,
    output logic                o_rd_read,
    input  logic [K_DWIDTH-1:0] i_rd_data,
    input  logic                i_rd_valid,
    output logic [K_DWIDTH-1:0] o_data,
    output logic                o_data_valid,
    input  logic                i_data_ready
);
    localparam int K_PW = (K_FIFO_DEPTH > 1) ? $clog2(K_FIFO_DEPTH) : 1;
    localparam int K_CW = $clog2(K_FIFO_DEPTH + 1);
    localparam int K_TW = $clog2(K_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [K_AWIDTH-1:0] addr;
    logic [K_LWIDTH-1:0] rem;
    logic [K_TW-1:0]     tcnt;
    logic                done_q;
    logic                err_q;

    logic [K_DWIDTH-1:0] mem [K_FIFO_DEPTH];
    logic [K_PW-1:0]     wptr;
    logic [K_PW-1:0]     rptr;
    logic [K_CW-1:0]     count;

    logic fifo_full;
    logic fifo_empty;
    logic start_ok;
    logic start_nop;
    logic issue;
    logic accept;
    logic expire;
    logic push;
    logic pop;
    logic flush;

    assign fifo_full  = (count == K_CW'(K_FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign start_ok   = (state == S_IDLE) && i_start && (i_len != '0);
    assign start_nop  = (state == S_IDLE) && i_start && (i_len == '0);
    assign issue      = (state == S_ISSUE) && !fifo_full;
    // The read pulse lives in ISSUE, so a valid seen in WAIT is always after it.
    assign accept     = (state == S_WAIT) && i_rd_valid;
    assign expire     = (state == S_WAIT) && !i_rd_valid && (tcnt == K_TW'(1));
    assign push       = accept;
    assign pop        = !fifo_empty && i_data_ready;
    assign flush      = expire;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (!fifo_full) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (accept) begin
                    state_nxt = (rem == K_LWIDTH'(1)) ? S_DRAIN : S_ISSUE;
                end else if (expire) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (state != S_IDLE);
        o_rd_read    = issue;
        o_rd_addr    = addr;
        o_done       = done_q;
        o_err        = err_q;
        o_data_valid = !fifo_empty;
        o_data       = fifo_empty ? '0 : mem[rptr];
    end

    // addr only advances when another read follows, so it keeps the last issued address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr   <= '0;
            rem    <= '0;
            tcnt   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= start_nop || expire || ((state == S_DRAIN) && fifo_empty);
            err_q  <= expire;
            if (start_ok) begin
                addr <= i_base_addr;
                rem  <= i_len;
            end
            if (issue) begin
                tcnt <= K_TW'(K_TIMEOUT);
            end else if ((state == S_WAIT) && !i_rd_valid) begin
                tcnt <= tcnt - K_TW'(1);
            end
            if (accept) begin
                rem <= rem - K_LWIDTH'(1);
                if (rem != K_LWIDTH'(1)) addr <= addr + K_AWIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + K_PW'(1);
            if (pop) rptr <= rptr + K_PW'(1);
            if (push && !pop) begin
                count <= count + K_CW'(1);
            end else if (!push && pop) begin
                count <= count - K_CW'(1);
            end
        end
    end

    // Push never coincides with a flush: a timeout requires the absence of valid.
    always_ff @(posedge i_clk) begin
        if (push) mem[wptr] <= i_rd_data;
    end

endmodule

// File: tb/tb_reg_rd_burst.sv
// Directed bench for reg_rd_burst: a 1-cycle slave returns addr[7:0], a negedge
// monitor logs reads, stream pops and done pulses for the checks below.
`timescale 1ns/1ps
module tb_reg_rd_burst;
    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [15:0] i_base_addr;
    logic [7:0]  i_len;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [15:0] o_rd_addr;
    logic        o_rd_read;
    logic [7:0]  i_rd_data;
    logic        i_rd_valid;
    logic [7:0]  o_data;
    logic        o_data_valid;
    logic        i_data_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rd_addr_log[$];
    int rd_cyc_log[$];
    int out_log[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int err_cnt = 0;
    int anomaly = 0;
    int slave_limit = 0;
    int served = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_data = 8'h00;
    logic       late_valid = 1'b0;

    reg_rd_burst dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_len        (i_len),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_rd_addr    (o_rd_addr),
        .o_rd_read    (o_rd_read),
        .i_rd_data    (i_rd_data),
        .i_rd_valid   (i_rd_valid),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc = cyc + 1;

    // Slave answers a read seen in cycle k with valid during cycle k+1, up to slave_limit reads.
    always @(negedge i_clk) begin
        i_rd_valid = pend | late_valid;
        i_rd_data  = pend ? pend_data : 8'hEE;
        pend = 1'b0;
        if (o_rd_read && (served < slave_limit)) begin
            pend      = 1'b1;
            pend_data = o_rd_addr[7:0];
            served++;
        end
    end

    always @(negedge i_clk) begin
        if (o_rd_read) begin
            rd_addr_log.push_back(int'(o_rd_addr));
            rd_cyc_log.push_back(cyc);
        end
        if (o_data_valid && i_data_ready) out_log.push_back(int'(o_data));
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (o_err) err_cnt++;
        end
        if (o_err && !o_done) anomaly++;
        if (o_done && o_rd_read) anomaly++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] base, input logic [7:0] len);
        @(posedge i_clk);
        #1;
        i_start     = 1'b1;
        i_base_addr = base;
        i_len       = len;
        start_cyc   = cyc;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic waitDone(input int base, input int budget);
        int n;
        n = 0;
        while ((done_cnt == base) && (n < budget)) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        checkOutput("done_seen", done_cnt > base, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ra, oa, db, eb, sc;
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_base_addr  = '0;
        i_len        = '0;
        i_data_ready = 1'b0;

        #12;
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_err", o_err, 0);
        checkOutput("rst_rd_read", o_rd_read, 0);
        checkOutput("rst_rd_addr", o_rd_addr, 0);
        checkOutput("rst_data_valid", o_data_valid, 0);
        checkOutput("rst_data", o_data, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        tick(2);

        // Single burst, 1-cycle slave.
        $display("[TB] single burst base=0x0010 len=3");
        i_data_ready = 1'b1;
        slave_limit = served + 100;
        ra = rd_addr_log.size(); oa = out_log.size(); db = done_cnt; eb = err_cnt;
        applyStimulus(16'h0010, 8'd3);
        waitDone(db, 40);
        checkOutput("t1_nreads", rd_addr_log.size() - ra, 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t1_addr%0d", i), rd_addr_log[ra+i], 32'h10 + i);
            checkOutput($sformatf("t1_rdcyc%0d", i), rd_cyc_log[ra+i] - start_cyc, 1 + 2*i);
        end
        checkOutput("t1_nout", out_log.size() - oa, 3);
        for (int i = 0; i < 3; i++) checkOutput($sformatf("t1_out%0d", i), out_log[oa+i], 32'h10 + i);
        checkOutput("t1_done_cyc", done_cyc - start_cyc, 9);
        checkOutput("t1_err", err_cnt - eb, 0);
        checkOutput("t1_busy", o_busy, 0);
        tick(2);
        checkOutput("t1_done_once", done_cnt - db, 1);

        // Backpressure: FIFO fills at 4 words and issuing stalls.
        $display("[TB] backpressure base=0x0020 len=6");
        i_data_ready = 1'b0;
        ra = rd_addr_log.size(); oa = out_log.size(); db = done_cnt; eb = err_cnt;
        applyStimulus(16'h0020, 8'd6);
        tick(30);
        checkOutput("t2_stalled_reads", rd_addr_log.size() - ra, 4);
        checkOutput("t2_busy", o_busy, 1);
        checkOutput("t2_rd_read_low", o_rd_read, 0);
        checkOutput("t2_head_valid", o_data_valid, 1);
        checkOutput("t2_head", o_data, 8'h20);
        i_data_ready = 1'b1;
        waitDone(db, 100);
        checkOutput("t2_nreads", rd_addr_log.size() - ra, 6);
        checkOutput("t2_nout", out_log.size() - oa, 6);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("t2_out%0d", i), out_log[oa+i], 32'h20 + i);
        checkOutput("t2_err", err_cnt - eb, 0);

        // Timeout on the second read with one word buffered.
        $display("[TB] timeout base=0x0040 len=2");
        i_data_ready = 1'b0;
        slave_limit = served + 1;
        ra = rd_addr_log.size(); oa = out_log.size(); db = done_cnt; eb = err_cnt;
        applyStimulus(16'h0040, 8'd2);
        waitDone(db, 60);
        checkOutput("t3_nreads", rd_addr_log.size() - ra, 2);
        checkOutput("t3_done_cyc", done_cyc - start_cyc, 19);
        checkOutput("t3_err", err_cnt - eb, 1);
        checkOutput("t3_busy", o_busy, 0);
        checkOutput("t3_flushed", o_data_valid, 0);
        late_valid = 1'b1;
        tick(1);
        late_valid = 1'b0;
        tick(2);
        checkOutput("t3_late_ignored", o_data_valid, 0);
        checkOutput("t3_late_busy", o_busy, 0);
        checkOutput("t3_done_once", done_cnt - db, 1);

        // Address wrap.
        $display("[TB] wrap base=0xFFFF len=2");
        i_data_ready = 1'b1;
        slave_limit = served + 100;
        ra = rd_addr_log.size(); oa = out_log.size(); db = done_cnt;
        applyStimulus(16'hFFFF, 8'd2);
        waitDone(db, 40);
        checkOutput("t4_addr0", rd_addr_log[ra], 32'hFFFF);
        checkOutput("t4_addr1", rd_addr_log[ra+1], 32'h0000);
        checkOutput("t4_out0", out_log[oa], 32'hFF);
        checkOutput("t4_out1", out_log[oa+1], 32'h00);

        // Zero-length command, then a start while busy.
        $display("[TB] len=0 and start while busy");
        ra = rd_addr_log.size(); oa = out_log.size(); db = done_cnt; eb = err_cnt;
        applyStimulus(16'h1234, 8'd0);
        waitDone(db, 5);
        tick(3);
        checkOutput("t5_nop_reads", rd_addr_log.size() - ra, 0);
        checkOutput("t5_nop_done_cyc", done_cyc - start_cyc, 1);
        checkOutput("t5_nop_done_once", done_cnt - db, 1);
        checkOutput("t5_nop_err", err_cnt - eb, 0);
        checkOutput("t5_nop_busy", o_busy, 0);
        db = done_cnt;
        applyStimulus(16'h0050, 8'd2);
        sc = start_cyc;
        applyStimulus(16'h0090, 8'd5);
        waitDone(db, 40);
        tick(5);
        checkOutput("t5_busy_start_cyc", start_cyc - sc, 2);
        checkOutput("t5_nreads", rd_addr_log.size() - ra, 2);
        checkOutput("t5_addr0", rd_addr_log[ra], 32'h50);
        checkOutput("t5_addr1", rd_addr_log[ra+1], 32'h51);
        checkOutput("t5_nout", out_log.size() - oa, 2);
        checkOutput("t5_idle", o_busy, 0);

        // Async reset in WAIT with two words buffered.
        $display("[TB] reset mid-burst");
        i_data_ready = 1'b0;
        slave_limit = served + 2;
        db = done_cnt;
        applyStimulus(16'h0060, 8'd4);
        tick(8);
        checkOutput("t6_pre_valid", o_data_valid, 1);
        checkOutput("t6_pre_busy", o_busy, 1);
        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("t6_busy", o_busy, 0);
        checkOutput("t6_data_valid", o_data_valid, 0);
        checkOutput("t6_data", o_data, 0);
        checkOutput("t6_rd_addr", o_rd_addr, 0);
        checkOutput("t6_rd_read", o_rd_read, 0);
        checkOutput("t6_done", o_done, 0);
        tick(2);
        checkOutput("t6_no_done", done_cnt - db, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_data_ready = 1'b1;
        slave_limit = served + 100;
        ra = rd_addr_log.size(); oa = out_log.size(); db = done_cnt; eb = err_cnt;
        applyStimulus(16'h0070, 8'd2);
        waitDone(db, 40);
        checkOutput("t6_addr0", rd_addr_log[ra], 32'h70);
        checkOutput("t6_addr1", rd_addr_log[ra+1], 32'h71);
        checkOutput("t6_out0", out_log[oa], 32'h70);
        checkOutput("t6_out1", out_log[oa+1], 32'h71);
        checkOutput("t6_err", err_cnt - eb, 0);

        checkOutput("done_err_rules", anomaly, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
